// File: rtl/regfile_sb_if.sv
// Decode/writeback bus for the register file: two read ports with busy flags,
// one writeback port, one issue port, and the pipeline flush.
interface regfile_sb_if #(
    parameter int CPU_WIDTH = 16,
    parameter int ADDR_W    = 3
);
    logic [ADDR_W-1:0]    rs1_addr;
    logic [ADDR_W-1:0]    rs2_addr;
    logic [CPU_WIDTH-1:0] rs1_data;
    logic [CPU_WIDTH-1:0] rs2_data;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [CPU_WIDTH-1:0] wr_data;
    logic                 iss_en;
    logic [ADDR_W-1:0]    iss_addr;
    logic                 flush;
    logic [ADDR_W:0]      busy_cnt;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with writeback-to-read bypass and a per-register busy
// scoreboard (with running count) so decode can stall on RAW hazards.
module regfile_sb #(
    parameter int CPU_WIDTH = 16,
    parameter int ADDR_W    = 3,
    parameter int ZERO_REG  = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [CPU_WIDTH-1:0] rf_reg [DEPTH];
    logic [DEPTH-1:0]     busy_reg;
    logic [DEPTH-1:0]     busy_next;
    logic [ADDR_W:0]      busy_cnt_reg;
    logic [ADDR_W:0]      busy_cnt_next;
    logic                 wr_ok;
    logic                 iss_ok;

    assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (wr_ok && (bus.wr_addr == IDX)) begin
                    rf_reg[gi] <= bus.wr_data;
                end
            end

            // Priority flush < writeback clear < issue set: a same-cycle issue
            // always leaves the bit set because it names a newer producer.
            assign busy_next[gi] = (iss_ok && (bus.iss_addr == IDX)) |
                                   (busy_reg[gi] & ~bus.flush &
                                    ~(bus.wr_en && (bus.wr_addr == IDX)));
        end
    endgenerate

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign bus.busy_cnt = busy_cnt_reg;

    always_comb begin
        bus.rs1_data = rf_reg[bus.rs1_addr];
        bus.rs1_busy = busy_reg[bus.rs1_addr];
        if ((ZERO_REG != 0) && (bus.rs1_addr == '0)) begin
            bus.rs1_data = '0;
            bus.rs1_busy = 1'b0;
        end else if (bus.wr_en && (bus.wr_addr == bus.rs1_addr)) begin
            bus.rs1_data = bus.wr_data;
            bus.rs1_busy = 1'b0;
        end
    end

    always_comb begin
        bus.rs2_data = rf_reg[bus.rs2_addr];
        bus.rs2_busy = busy_reg[bus.rs2_addr];
        if ((ZERO_REG != 0) && (bus.rs2_addr == '0)) begin
            bus.rs2_data = '0;
            bus.rs2_busy = 1'b0;
        end else if (bus.wr_en && (bus.wr_addr == bus.rs2_addr)) begin
            bus.rs2_data = bus.wr_data;
            bus.rs2_busy = 1'b0;
        end
    end
endmodule
